seq_magnitude_comparator: RTL and testbench
===========================================

# seq_magnitude_comparator

Multi-cycle, parametrised magnitude comparator that evaluates two WIDTH-bit operands one SLICE-bit slice per clock, MSB slice first, and stops at the first unequal slice. Supports unsigned and two's-complement signed comparison with a start/busy/done handshake and registered, held results. It is the clocked, width-generic successor to the 4-bit combinational comparator. It serves wide datapaths where a full-width single-cycle compare would limit timing.

## Interface
- WIDTH, 16, operand width in bits; must be an integer multiple of SLICE.
- SLICE, 4, bits compared per cycle; 1 <= SLICE <= WIDTH.
- NSLICE (localparam), WIDTH/SLICE, number of slices.
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  1 = two's-complement compare, 0 = unsigned; captured with start.
- A  in  WIDTH  operand A; captured with start.
- B  in  WIDTH  operand B; captured with start.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when the result is updated.
- gt / lt / eq  out  1 each  registered result of A vs B, held until the next completion.
- slices_used  out  $clog2(NSLICE+1)  number of slices examined for the last result (1..NSLICE).

## Operation
- States: IDLE, COMPARE.
- IDLE, start=1:
  - A, B and signed_mode are latched.
  - Slice index idx is set to NSLICE-1.
  - The state moves to COMPARE and busy is set.
- IDLE, start=0: hold.
- COMPARE, each cycle, compare slice idx of the latched A and B (bits idx*SLICE+SLICE-1 : idx*SLICE).
  - Signed mode: on the top slice only, invert the MSB of both operand slices before the unsigned compare. Lower slices are always unsigned.
  - Slices unequal: set gt or lt accordingly, clear eq, and finish.
  - Slices equal and idx==0: set eq, clear gt/lt, and finish.
  - Slices equal and idx>0: decrement idx and stay in COMPARE.
- Finish (single clock edge):
  - gt/lt/eq are updated.
  - slices_used = NSLICE - idx.
  - done=1 and busy=0.
  - The state returns to IDLE.
- Exactly one of gt/lt/eq is high after the first completion; all three are 0 before it.
- start while busy is ignored: there is no queueing and the latched operands are not modified.
- Changes on A/B/signed_mode after capture have no effect on the operation in flight.

## Timing
- Reset values: state=IDLE, busy=0, done=0, gt=0, lt=0, eq=0, slices_used=0.
- Start accepted at edge E0. busy is high from E0.
- The result, done and busy=0 appear after edge E0+k, where k = slices examined (1..NSLICE).
  - Best-case latency: 1 cycle.
  - Worst-case latency: NSLICE cycles (equal operands, or a difference only in slice 0).
- done is high for exactly one cycle. Results remain stable until the next finish edge.
- Back-to-back operation: start high during the done cycle is accepted at that edge (the state is IDLE). Throughput is one compare per k+1 cycles.
- Reset mid-operation:
  - The compare is aborted and no done is produced.
  - All outputs return to their reset values at the next edge.
  - A start sampled together with rst is ignored.
- SLICE==WIDTH degenerates to a registered single-cycle compare (k=1 always).

## Structure
- Shared package comparator_pkg:
  - State encoding constants ST_IDLE, ST_COMPARE.
  - Result encoding constants CMP_LT, CMP_EQ, CMP_GT.
- One sub-module, slice_compare:
  - Combinational, parameter SLICE.
  - Inputs a, b, flip_msb.
  - Outputs gt, lt, eq.
  - This is the width-generic form of the existing 4-bit comparator.
- The top level holds the FSM, operand registers, idx counter and result registers.

## Test plan
All scenarios use WIDTH=16, SLICE=4.
1. rst high for 2 cycles, then idle with start=0 -> busy/done/gt/lt/eq=0 and slices_used=0, held indefinitely.
2. Unsigned, A=16'h1234, B=16'h1235 -> lt=1, gt=eq=0, slices_used=4, done exactly 4 cycles after the start edge, busy high for those 4 cycles.
3. A=16'h9000, B=16'h1000:
   - Unsigned -> gt=1, slices_used=1, done 1 cycle after start.
   - Repeated with signed_mode=1 -> lt=1, slices_used=1.
4. Signed, A=B=16'hFFFF -> eq=1, slices_used=4. Then A=16'h8000, B=16'h7FFF signed -> lt=1, slices_used=1.
5. Start A=16'h00F0, B=16'h00E0 (unsigned):
   - Pulse start with A=B=0 mid-operation -> ignored; result gt=1, slices_used=3.
   - Start held high on the done cycle with A=16'h0001, B=16'h0002 -> accepted; lt=1 after 4 more cycles.
6. rst asserted on the 2nd cycle of a compare of A=16'h0001, B=16'h0001 -> no done pulse, all outputs cleared. A following start with A=16'h0002, B=16'h0001 -> gt=1, slices_used=4.

Source files
------------

// File: rtl/comparator_pkg.sv
// Shared encodings for the sliced magnitude comparator: FSM states and
// the one-hot {gt, lt, eq} result vector.
package comparator_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_COMPARE = 1'b1
    } state_t;

    // Result vector bit order is {gt, lt, eq}
    localparam logic [2:0] CMP_NONE = 3'b000;
    localparam logic [2:0] CMP_GT   = 3'b100;
    localparam logic [2:0] CMP_LT   = 3'b010;
    localparam logic [2:0] CMP_EQ   = 3'b001;

endpackage

// File: rtl/slice_compare.sv
// Combinational SLICE-bit magnitude compare; flip_msb inverts both sign bits
// so a two's-complement slice can be ordered with an unsigned compare.
module slice_compare #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             flip_msb,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    logic [SLICE-1:0] a_m;
    logic [SLICE-1:0] b_m;

    always_comb begin
        a_m            = a;
        b_m            = b;
        a_m[SLICE-1]   = a[SLICE-1] ^ flip_msb;
        b_m[SLICE-1]   = b[SLICE-1] ^ flip_msb;
    end

    assign gt = (a_m > b_m);
    assign lt = (a_m < b_m);
    assign eq = (a_m == b_m);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// Multi-cycle comparator: walks the latched operands one slice per clock,
// MSB slice first, and finishes on the first unequal slice.
module seq_magnitude_comparator
    import comparator_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic                               signed_mode,
    input  logic [WIDTH-1:0]                   A,
    input  logic [WIDTH-1:0]                   B,
    output logic                               busy,
    output logic                               done,
    output logic                               gt,
    output logic                               lt,
    output logic                               eq,
    output logic [$clog2(WIDTH/SLICE+1)-1:0]   slices_used
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam int CNTW   = $clog2(NSLICE + 1);
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              signed_q, signed_d;
    logic [IDXW-1:0]   idx_q, idx_d;
    logic [2:0]        res_q, res_d;
    logic [CNTW-1:0]   slices_q, slices_d;
    logic              done_q, done_d;

    logic [SLICE-1:0]  a_slice;
    logic [SLICE-1:0]  b_slice;
    logic              flip_msb;
    logic              s_gt;
    logic              s_lt;
    logic              s_eq;

    assign a_slice  = a_q[int'(idx_q) * SLICE +: SLICE];
    assign b_slice  = b_q[int'(idx_q) * SLICE +: SLICE];
    // Only the top slice carries the sign bit
    assign flip_msb = signed_q && (idx_q == IDX_TOP);

    slice_compare #(
        .SLICE (SLICE)
    ) u_slice_compare (
        .a        (a_slice),
        .b        (b_slice),
        .flip_msb (flip_msb),
        .gt       (s_gt),
        .lt       (s_lt),
        .eq       (s_eq)
    );

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        res_d    = res_q;
        slices_d = slices_q;
        done_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    signed_d = signed_mode;
                    idx_d    = IDX_TOP;
                    state_d  = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                if (!s_eq || idx_q == '0) begin
                    if (s_gt) begin
                        res_d = CMP_GT;
                    end else if (s_lt) begin
                        res_d = CMP_LT;
                    end else begin
                        res_d = CMP_EQ;
                    end
                    slices_d = CNTW'(NSLICE) - CNTW'(idx_q);
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            res_q    <= CMP_NONE;
            slices_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            res_q    <= res_d;
            slices_q <= slices_d;
            done_q   <= done_d;
        end
    end

    assign busy         = (state_q == ST_COMPARE);
    assign done         = done_q;
    assign {gt, lt, eq} = res_q;
    assign slices_used  = slices_q;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// Testbench for seq_magnitude_comparator (WIDTH=16, SLICE=4): vector table,
// hand-written handshake/reset sequences and a result scoreboard.
module tb_seq_magnitude_comparator;

    localparam int WIDTH  = 16;
    localparam int SLICE  = 4;
    localparam int NSLICE = 4;

    localparam logic [2:0] R_GT = 3'b100;
    localparam logic [2:0] R_LT = 3'b010;
    localparam logic [2:0] R_EQ = 3'b001;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              signed_mode;
    logic [WIDTH-1:0]  A;
    logic [WIDTH-1:0]  B;
    logic              busy;
    logic              done;
    logic              gt;
    logic              lt;
    logic              eq;
    logic [2:0]        slices_used;

    seq_magnitude_comparator #(
        .WIDTH (WIDTH),
        .SLICE (SLICE)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .done        (done),
        .gt          (gt),
        .lt          (lt),
        .eq          (eq),
        .slices_used (slices_used)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] res;
        int         slices;
        int         start_cyc;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [2:0]  res;
        int          slices;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    logic prev_done = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pushExp(input logic [2:0] res, input int slices);
        exp_t e;
        e.res       = res;
        e.slices    = slices;
        e.start_cyc = cyc;
        sb.push_back(e);
    endtask

    // Scoreboard: every done pulse must match the oldest accepted compare
    always @(negedge clk) begin
        if (done) begin
            checkOutput("done_single_cycle", prev_done, 0);
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_done: got done=1, expected no pending compare");
            end else begin
                mon_e = sb.pop_front();
                checkOutput("result_gt_lt_eq", {gt, lt, eq}, mon_e.res);
                checkOutput("slices_used", slices_used, mon_e.slices);
                checkOutput("latency", cyc - mon_e.start_cyc - 1, mon_e.slices);
                checkOutput("busy_at_done", busy, 0);
            end
        end
        prev_done = done;
    end

    task automatic waitDone();
        int n = 0;
        while (!done && n < NSLICE + 3) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("[TB] FAIL done_timeout: got no done within %0d cycles, expected done", n);
            sb.delete();
        end
    endtask

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input logic sm, input logic [2:0] res,
                                 input int slices);
        logic [31:0] r;
        @(negedge clk);
        A           = a;
        B           = b;
        signed_mode = sm;
        start       = 1'b1;
        pushExp(res, slices);
        @(negedge clk);
        start       = 1'b0;
        r           = $urandom;
        A           = r[15:0];
        B           = r[31:16];
        signed_mode = ~sm;
        if (slices > 1) checkOutput("busy_during_compare", busy, 1);
        waitDone();
    endtask

    function automatic int modelSlices(input logic [15:0] a, input logic [15:0] b);
        for (int i = NSLICE - 1; i >= 0; i--) begin
            if (a[i*SLICE +: SLICE] != b[i*SLICE +: SLICE]) return NSLICE - i;
        end
        return NSLICE;
    endfunction

    function automatic logic [2:0] modelRes(input logic [15:0] a, input logic [15:0] b,
                                            input logic sm);
        if (a == b) return R_EQ;
        if (sm) return ($signed(a) > $signed(b)) ? R_GT : R_LT;
        return (a > b) ? R_GT : R_LT;
    endfunction

    vec_t vecs[13];

    initial begin
        vecs[0]  = '{16'h1234, 16'h1235, 1'b0, R_LT, 4};
        vecs[1]  = '{16'h9000, 16'h1000, 1'b0, R_GT, 1};
        vecs[2]  = '{16'h9000, 16'h1000, 1'b1, R_LT, 1};
        vecs[3]  = '{16'hFFFF, 16'hFFFF, 1'b1, R_EQ, 4};
        vecs[4]  = '{16'h8000, 16'h7FFF, 1'b1, R_LT, 1};
        vecs[5]  = '{16'h0000, 16'h0000, 1'b0, R_EQ, 4};
        vecs[6]  = '{16'h00F0, 16'h00E0, 1'b0, R_GT, 3};
        vecs[7]  = '{16'h0001, 16'h0002, 1'b0, R_LT, 4};
        vecs[8]  = '{16'h8000, 16'h7FFF, 1'b0, R_GT, 1};
        vecs[9]  = '{16'hFFFF, 16'h0001, 1'b1, R_LT, 1};
        vecs[10] = '{16'h0F00, 16'h0E00, 1'b0, R_GT, 2};
        vecs[11] = '{16'hFFF0, 16'hFFFE, 1'b1, R_LT, 4};
        vecs[12] = '{16'h0001, 16'h0000, 1'b1, R_GT, 4};

        rst         = 1'b1;
        start       = 1'b0;
        signed_mode = 1'b0;
        A           = '0;
        B           = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_busy", busy, 0);
            checkOutput("reset_done", done, 0);
            checkOutput("reset_result", {gt, lt, eq}, 0);
            checkOutput("reset_slices_used", slices_used, 0);
        end

        $display("[TB] vector table");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].res, vecs[i].slices);
        end
        repeat (3) @(negedge clk);
        checkOutput("result_held", {gt, lt, eq}, vecs[12].res);
        checkOutput("slices_held", slices_used, vecs[12].slices);

        $display("[TB] start while busy and back-to-back start");
        @(negedge clk);
        A = 16'h00F0; B = 16'h00E0; signed_mode = 1'b0; start = 1'b1;
        pushExp(R_GT, 3);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_first_cycle", busy, 1);
        @(negedge clk);
        A = 16'h0000; B = 16'h0000; start = 1'b1;
        @(negedge clk);
        start = 1'b0; A = 16'h0001; B = 16'h0002;
        waitDone();
        start = 1'b1;
        pushExp(R_LT, 4);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_back_to_back", busy, 1);
        waitDone();

        $display("[TB] reset mid-compare");
        @(negedge clk);
        A = 16'h0001; B = 16'h0001; signed_mode = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_before_abort", busy, 1);
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_result", {gt, lt, eq}, 0);
        checkOutput("abort_slices_used", slices_used, 0);
        repeat (NSLICE + 1) @(negedge clk);
        checkOutput("abort_stays_idle", busy, 0);
        applyStimulus(16'h0002, 16'h0001, 1'b0, R_GT, 4);

        $display("[TB] random vectors");
        for (int i = 0; i < 12; i++) begin
            logic [31:0] r1;
            logic [31:0] r2;
            logic [15:0] a;
            logic [15:0] b;
            logic        sm;
            r1 = $urandom;
            r2 = $urandom;
            a  = r1[15:0];
            sm = r1[16];
            case (i % 3)
                0:       b = a;
                1:       b = {a[15:8], r2[7:0]};
                default: b = r2[15:0];
            endcase
            applyStimulus(a, b, sm, modelRes(a, b, sm), modelSlices(a, b));
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
